// File: rtl/mul_operand_issuer.sv
// Operand-issue stage for buffered_mul: queues {a,b} pairs and keeps exactly one multiply in flight.
// Optional CONST_TIME_EN: results are released a fixed FIXED_GAP cycles after issue.
module mul_operand_issuer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FIXED_GAP = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       iss_valid,
    output logic [WIDTH-1:0]           iss_a,
    output logic [WIDTH-1:0]           iss_b,
    input  logic                       done_valid,
    input  logic [2*WIDTH-1:0]         done_result,
    output logic                       res_valid,
    output logic [2*WIDTH-1:0]         res_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_spurious
`ifdef CONST_TIME_EN
    ,
    output logic                       err_late
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned GW = $clog2(FIXED_GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FIXED_GAP < 2) begin : g_bad_param
        $error("mul_operand_issuer: DEPTH must be a power of two >= 2 and FIXED_GAP >= 2");
    end

    state_t           state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic             push;
    logic             pop;

`ifdef CONST_TIME_EN
    logic [GW-1:0]    gap_cnt;
    logic             got_done;
    logic [RW-1:0]    cap_result;
`endif

    // Full blocks a push even when a pop happens in the same cycle.
    assign in_ready = (fifo_count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (fifo_count != '0);

    // Operand storage; entries are dropped logically on reset via the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            iss_valid    <= 1'b0;
            iss_a        <= '0;
            iss_b        <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            err_spurious <= 1'b0;
`ifdef CONST_TIME_EN
            err_late     <= 1'b0;
            gap_cnt      <= '0;
            got_done     <= 1'b0;
            cap_result   <= '0;
`endif
        end else begin
            iss_valid <= 1'b0;
            res_valid <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (done_valid) begin
                        err_spurious <= 1'b1;
                    end
                    if (pop) begin
                        iss_valid <= 1'b1;
                        iss_a     <= mem_a[rd_ptr];
                        iss_b     <= mem_b[rd_ptr];
                        state     <= S_ISSUE;
`ifdef CONST_TIME_EN
                        gap_cnt   <= GW'(1);
                        got_done  <= 1'b0;
`endif
                    end
                end

                S_ISSUE: begin
                    if (done_valid) begin
                        err_spurious <= 1'b1;
                    end
                    state <= S_WAIT;
`ifdef CONST_TIME_EN
                    gap_cnt <= gap_cnt + GW'(1);
`endif
                end

                S_WAIT: begin
`ifdef CONST_TIME_EN
                    // First done in the window is captured; release only at the window end.
                    gap_cnt <= gap_cnt + GW'(1);
                    if (done_valid && !got_done) begin
                        got_done   <= 1'b1;
                        cap_result <= done_result;
                    end
                    if (gap_cnt == GW'(FIXED_GAP)) begin
                        res_valid <= 1'b1;
                        state     <= S_IDLE;
                        if (got_done) begin
                            res_data <= cap_result;
                        end else if (done_valid) begin
                            res_data <= done_result;
                        end else begin
                            res_data <= '0;
                            err_late <= 1'b1;
                        end
                    end
`else
                    if (done_valid) begin
                        res_data  <= done_result;
                        res_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
`endif
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_operand_issuer.sv
// Directed self-checking bench for mul_operand_issuer; the bench plays the producer and a scripted buffered_mul.
module tb_mul_operand_issuer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             iss_valid;
    logic [WIDTH-1:0] iss_a;
    logic [WIDTH-1:0] iss_b;
    logic             done_valid;
    logic [7:0]       done_result;
    logic             res_valid;
    logic [7:0]       res_data;
    logic [2:0]       fifo_count;
    logic             err_spurious;
`ifdef CONST_TIME_EN
    logic             err_late;
`endif

    int n_checks;
    int n_fail;
    int iss_cnt;
    logic [7:0] res_q[$];

    mul_operand_issuer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .FIXED_GAP(GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .iss_valid   (iss_valid),
        .iss_a       (iss_a),
        .iss_b       (iss_b),
        .done_valid  (done_valid),
        .done_result (done_result),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .fifo_count  (fifo_count),
        .err_spurious(err_spurious)
`ifdef CONST_TIME_EN
        ,
        .err_late    (err_late)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (iss_valid) iss_cnt++;
        if (res_valid) res_q.push_back(res_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
        done_valid = 1'b0; done_result = 8'h00;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %0b expected 0", iss_valid); end
        n_checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res: got %0b/%0h expected 0/0", res_valid, res_data); end
        n_checks++; if (err_spurious !== 1'b0 || iss_a !== 4'd0 || iss_b !== 4'd0) begin n_fail++; $display("FAIL reset_regs: got err=%0b a=%0d b=%0d expected 0", err_spurious, iss_a, iss_b); end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++; if (fifo_count !== 3'd0 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got count=%0d iss=%0b expected 0/0", fifo_count, iss_valid); end
    endtask

    task automatic test_single_op();
        iss_cnt = 0; res_q.delete();
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5;
        tick();
        in_valid = 1'b0;
        n_checks++; if (fifo_count !== 3'd1 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL single_push: got count=%0d iss=%0b expected 1/0", fifo_count, iss_valid); end
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_a !== 4'd3 || iss_b !== 4'd5) begin n_fail++; $display("FAIL single_issue: got v=%0b a=%0d b=%0d expected 1/3/5", iss_valid, iss_a, iss_b); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_pop: got %0d expected 0", fifo_count); end
        tick();
        n_checks++; if (iss_valid !== 1'b0 || iss_a !== 4'd3) begin n_fail++; $display("FAIL single_iss_pulse: got v=%0b a=%0d expected 0/3", iss_valid, iss_a); end
        tick(); tick();
        done_valid = 1'b1; done_result = 8'h0F;
        tick();
        done_valid = 1'b0;
        n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h0F) begin n_fail++; $display("FAIL single_result: got v=%0b d=%0h expected 1/0f", res_valid, res_data); end
        tick();
        n_checks++; if (res_valid !== 1'b0 || res_data !== 8'h0F) begin n_fail++; $display("FAIL single_res_pulse: got v=%0b d=%0h expected 0/0f", res_valid, res_data); end
        n_checks++; if (iss_cnt !== 1 || err_spurious !== 1'b0) begin n_fail++; $display("FAIL single_counts: got iss=%0d err=%0b expected 1/0", iss_cnt, err_spurious); end
    endtask

    task automatic test_back_to_back();
        iss_cnt = 0; res_q.delete();
        in_valid = 1'b1; in_a = 4'd0; in_b = 4'd7;
        tick();
        in_a = 4'd15; in_b = 4'd15;
        tick();
        in_valid = 1'b0;
        n_checks++; if (iss_valid !== 1'b1 || iss_a !== 4'd0 || iss_b !== 4'd7) begin n_fail++; $display("FAIL b2b_issue0: got v=%0b a=%0d b=%0d expected 1/0/7", iss_valid, iss_a, iss_b); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_push_pop_count: got %0d expected 1", fifo_count); end
        tick();
        done_valid = 1'b1; done_result = 8'h00;
        tick();
        done_valid = 1'b0;
        n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h00) begin n_fail++; $display("FAIL b2b_res0: got v=%0b d=%0h expected 1/00", res_valid, res_data); end
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_a !== 4'd15 || iss_b !== 4'd15 || res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_issue1: got v=%0b a=%0d b=%0d rv=%0b expected 1/15/15/0", iss_valid, iss_a, iss_b, res_valid); end
        for (int k = 0; k < 4; k++) tick();
        done_valid = 1'b1; done_result = 8'hE1;
        tick();
        done_valid = 1'b0;
        n_checks++; if (res_valid !== 1'b1 || res_data !== 8'hE1) begin n_fail++; $display("FAIL b2b_res1: got v=%0b d=%0h expected 1/e1", res_valid, res_data); end
        tick();
        n_checks++; if (res_q.size() !== 2) begin n_fail++; $display("FAIL b2b_res_count: got %0d expected 2", res_q.size()); end
        else if (res_q[0] !== 8'h00 || res_q[1] !== 8'hE1) begin n_fail++; $display("FAIL b2b_order: got %0h,%0h expected 00,e1", res_q[0], res_q[1]); end
        n_checks++; if (iss_cnt !== 2 || err_spurious !== 1'b0) begin n_fail++; $display("FAIL b2b_iss_count: got iss=%0d err=%0b expected 2/0", iss_cnt, err_spurious); end
    endtask

    task automatic test_full();
        // One op goes in flight and never completes, so the queue cannot drain.
        in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_a = 4'(k + 2); in_b = 4'(k + 3);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %0b expected 1", k, in_ready); end
            tick();
        end
        in_a = 4'd9; in_b = 4'd9;
        n_checks++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_at_depth: got count=%0d ready=%0b expected 4/0", fifo_count, in_ready); end
        tick();
        n_checks++; if (fifo_count !== 3'd4 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL full_hold: got count=%0d iss=%0b expected 4/0", fifo_count, iss_valid); end
        in_valid = 1'b0;
        apply_reset();
        tick();
        n_checks++; if (fifo_count !== 3'd0 || in_ready !== 1'b1 || iss_valid !== 1'b0) begin n_fail++; $display("FAIL full_reset_drop: got count=%0d ready=%0b iss=%0b expected 0/1/0", fifo_count, in_ready, iss_valid); end
        done_valid = 1'b1; done_result = 8'h55;
        tick();
        done_valid = 1'b0;
        n_checks++; if (err_spurious !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL full_late_done: got err=%0b rv=%0b expected 1/0", err_spurious, res_valid); end
    endtask

    task automatic test_spurious();
        apply_reset();
        tick();
        n_checks++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_cleared: got %0b expected 0", err_spurious); end
        done_valid = 1'b1; done_result = 8'hAA;
        tick();
        done_valid = 1'b0;
        n_checks++; if (err_spurious !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h00) begin n_fail++; $display("FAIL spur_idle: got err=%0b rv=%0b d=%0h expected 1/0/00", err_spurious, res_valid, res_data); end
        tick(); tick(); tick();
        n_checks++; if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %0b expected 1", err_spurious); end
        apply_reset();
        tick();
        n_checks++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_reset: got %0b expected 0", err_spurious); end
    endtask

`ifdef CONST_TIME_EN
    task automatic test_const_time();
        logic [7:0] exp_d [3];
        int         done_at [3];
        logic [3:0] ops_a [3];
        logic [3:0] ops_b [3];
        ops_a[0] = 4'd0; ops_b[0] = 4'd9; exp_d[0] = 8'h00; done_at[0] = 2;
        ops_a[1] = 4'd6; ops_b[1] = 4'd6; exp_d[1] = 8'h24; done_at[1] = 5;
        ops_a[2] = 4'd1; ops_b[2] = 4'd1; exp_d[2] = 8'h00; done_at[2] = 0;
        for (int op = 0; op < 3; op++) begin
            in_valid = 1'b1; in_a = ops_a[op]; in_b = ops_b[op];
            tick();
            in_valid = 1'b0;
            tick();
            n_checks++; if (iss_valid !== 1'b1 || iss_a !== ops_a[op]) begin n_fail++; $display("FAIL ct_issue_%0d: got v=%0b a=%0d expected 1/%0d", op, iss_valid, iss_a, ops_a[op]); end
            for (int k = 1; k <= int'(GAP); k++) begin
                done_valid = (done_at[op] != 0 && k == done_at[op] + 1);
                done_result = (op == 1) ? 8'h24 : 8'h00;
                tick();
                done_valid = 1'b0;
                if (k < int'(GAP)) begin
                    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ct_early_%0d_%0d: got %0b expected 0", op, k, res_valid); end
                end
            end
            n_checks++; if (res_valid !== 1'b1 || res_data !== exp_d[op]) begin n_fail++; $display("FAIL ct_release_%0d: got v=%0b d=%0h expected 1/%0h", op, res_valid, res_data, exp_d[op]); end
            n_checks++; if (err_late !== (op == 2)) begin n_fail++; $display("FAIL ct_err_late_%0d: got %0b expected %0b", op, err_late, op == 2); end
            tick();
        end
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0; iss_cnt = 0;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        done_valid = 1'b0; done_result = '0;
        test_reset();
`ifdef CONST_TIME_EN
        test_const_time();
        apply_reset();
        tick();
`else
        test_single_op();
        test_back_to_back();
        test_full();
`endif
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
